// File: rtl/mem_access.sv
// MIPS32 memory-access stage: ALU passthrough, plus a req/ack data-bus transaction
// for loads and stores, with big-endian lane selection, extension, alignment and timeout checks.
module mem_access #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wReg_i,
  input  logic [4:0]  mem_wAddr_i,
  input  logic [31:0] mem_wData_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_sData_i,
  output logic        wb_wReg_o,
  output logic [4:0]  wb_wAddr_o,
  output logic [31:0] wb_wData_o,
  output logic        stall_req_o,
  output logic        exc_align_o,
  output logic        exc_timeout_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int unsigned TMO_W = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUS_TIMEOUT - 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       addr_q;
  logic [3:0]        op_q;
  logic [31:0]       sdata_q;
  logic [31:0]       rdata_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_flag;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] b);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = b[0];
      OP_LW, OP_SW:         bad = (b != 2'b00);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Big-endian lane pick: shifting left by the byte offset brings the addressed lane to the top.
  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] b,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = rdata << {b, 3'b000};
    res = '0;
    case (op)
      OP_LB:   res = {{24{sh[31]}}, sh[31:24]};
      OP_LBU:  res = {24'd0, sh[31:24]};
      OP_LH:   res = {{16{sh[31]}}, sh[31:16]};
      OP_LHU:  res = {16'd0, sh[31:16]};
      OP_LW:   res = rdata;
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] b);
    logic [3:0] sel;
    case (op)
      OP_LB, OP_LBU, OP_SB: sel = 4'b1000 >> b;
      OP_LH, OP_LHU, OP_SH: sel = b[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         sel = 4'b1111;
      default:              sel = 4'b0000;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] sdata);
    logic [31:0] wd;
    case (op)
      OP_SB:   wd = {4{sdata[7:0]}};
      OP_SH:   wd = {2{sdata[15:0]}};
      OP_SW:   wd = sdata;
      default: wd = '0;
    endcase
    return wd;
  endfunction

  // Transaction FSM and its latched operands
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      op_q     <= '0;
      sdata_q  <= '0;
      rdata_q  <= '0;
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mem(mem_op_i) && !misaligned(mem_op_i, mem_wData_i[1:0])) begin
            addr_q  <= mem_wData_i;
            op_q    <= mem_op_i;
            sdata_q <= mem_sData_i;
            tmo_cnt <= '0;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (bus_ack_i) begin
            rdata_q <= load_extract(op_q, addr_q[1:0], bus_rdata_i);
            state   <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_flag <= 1'b1;
            state    <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DONE: begin
          tmo_flag <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode; everything is forced quiet while reset is held
  always_comb begin
    wb_wReg_o     = 1'b0;
    wb_wAddr_o    = '0;
    wb_wData_o    = '0;
    stall_req_o   = 1'b0;
    exc_align_o   = 1'b0;
    exc_timeout_o = 1'b0;
    bus_req_o     = 1'b0;
    bus_we_o      = 1'b0;
    bus_addr_o    = '0;
    bus_sel_o     = '0;
    bus_wdata_o   = '0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          wb_wAddr_o = mem_wAddr_i;
          wb_wData_o = mem_wData_i;
          if (!is_mem(mem_op_i)) begin
            wb_wReg_o = mem_wReg_i;
          end else if (misaligned(mem_op_i, mem_wData_i[1:0])) begin
            exc_align_o = 1'b1;
          end else begin
            stall_req_o = 1'b1;
          end
        end
        S_ACCESS: begin
          stall_req_o = 1'b1;
          wb_wAddr_o  = mem_wAddr_i;
          wb_wData_o  = mem_wData_i;
          bus_req_o   = 1'b1;
          bus_we_o    = is_store(op_q);
          bus_addr_o  = {addr_q[31:2], 2'b00};
          bus_sel_o   = lane_sel(op_q, addr_q[1:0]);
          bus_wdata_o = store_data(op_q, sdata_q);
        end
        S_DONE: begin
          wb_wAddr_o = mem_wAddr_i;
          if (is_load(op_q)) begin
            wb_wData_o = rdata_q;
            wb_wReg_o  = mem_wReg_i;
          end else begin
            wb_wData_o = mem_wData_i;
          end
          if (tmo_flag) begin
            exc_timeout_o = 1'b1;
            wb_wReg_o     = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expectations queued when each step is driven, popped as outputs appear.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_wReg_i;
  logic [4:0]  mem_wAddr_i;
  logic [31:0] mem_wData_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_sData_i;
  logic        wb_wReg_o;
  logic [4:0]  wb_wAddr_o;
  logic [31:0] wb_wData_o;
  logic        stall_req_o;
  logic        exc_align_o;
  logic        exc_timeout_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access #(.BUS_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_wReg_i    (mem_wReg_i),
    .mem_wAddr_i   (mem_wAddr_i),
    .mem_wData_i   (mem_wData_i),
    .mem_op_i      (mem_op_i),
    .mem_sData_i   (mem_sData_i),
    .wb_wReg_o     (wb_wReg_o),
    .wb_wAddr_o    (wb_wAddr_o),
    .wb_wData_o    (wb_wData_o),
    .stall_req_o   (stall_req_o),
    .exc_align_o   (exc_align_o),
    .exc_timeout_o (exc_timeout_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_sel_o     (bus_sel_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_ack_i     (bus_ack_i),
    .bus_rdata_i   (bus_rdata_i)
  );

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but scoreboard is empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One aligned memory op from its IDLE cycle through DONE; waits < 0 means no ack ever.
  task automatic access(input string name, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata, input int waits,
                        input logic [31:0] e_baddr, input logic [3:0] e_sel, input logic e_we,
                        input logic [31:0] e_bwdata, input logic e_wreg, input logic [31:0] e_wbdata,
                        input logic e_tmo, input int e_stall);
    int stalls;
    cycle();
    mem_op_i = op; mem_wData_i = addr; mem_sData_i = sdata;
    mem_wAddr_i = 5'd7; mem_wReg_i = 1'b1; bus_ack_i = 1'b0;
    push(32'd1); push(32'd0);
    push(32'd1); push(e_baddr); push(32'(e_sel)); push(32'(e_we)); push(e_bwdata);
    push(32'(e_wreg)); push(e_wbdata); push(32'd7); push(32'(e_tmo)); push(32'd0);
    push(32'(e_stall));
    #1;
    chk({name, "/idle_stall"}, 32'(stall_req_o));
    chk({name, "/idle_bus_req"}, 32'(bus_req_o));
    stalls = stall_req_o ? 1 : 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      bus_ack_i   = (c == waits);
      bus_rdata_i = (c == waits) ? rdata : 32'hDEADBEEF;
      #1;
      if (c == 0) begin
        chk({name, "/bus_req"}, 32'(bus_req_o));
        chk({name, "/bus_addr"}, bus_addr_o);
        chk({name, "/bus_sel"}, 32'(bus_sel_o));
        chk({name, "/bus_we"}, 32'(bus_we_o));
        chk({name, "/bus_wdata"}, bus_wdata_o);
      end
      if (!stall_req_o) break;
      stalls++;
    end
    bus_ack_i = 1'b0;
    chk({name, "/wb_wReg"}, 32'(wb_wReg_o));
    chk({name, "/wb_wData"}, wb_wData_o);
    chk({name, "/wb_wAddr"}, 32'(wb_wAddr_o));
    chk({name, "/exc_timeout"}, 32'(exc_timeout_o));
    chk({name, "/done_bus_req"}, 32'(bus_req_o));
    chk({name, "/stall_cycles"}, 32'(stalls));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_op_i = 4'd5; mem_wData_i = 32'h0000_0100; mem_wAddr_i = 5'd5; mem_wReg_i = 1'b1;
    mem_sData_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;

    // Reset holds everything quiet even with an aligned load presented
    cycle(); cycle();
    push(32'd0); push(32'd0); push(32'd0); push(32'd0); push(32'd0); push(32'd0);
    chk("rst/stall", 32'(stall_req_o));
    chk("rst/bus_req", 32'(bus_req_o));
    chk("rst/wb_wReg", 32'(wb_wReg_o));
    chk("rst/wb_wData", wb_wData_o);
    chk("rst/wb_wAddr", 32'(wb_wAddr_o));
    chk("rst/exc_align", 32'(exc_align_o));

    // Non-memory passthrough
    cycle();
    rst = 1'b0;
    mem_op_i = 4'd0; mem_wData_i = 32'h1234_5678; mem_wAddr_i = 5'd3; mem_wReg_i = 1'b1;
    push(32'd1); push(32'h1234_5678); push(32'd3); push(32'd0); push(32'd0);
    #1;
    chk("pass/wb_wReg", 32'(wb_wReg_o));
    chk("pass/wb_wData", wb_wData_o);
    chk("pass/wb_wAddr", 32'(wb_wAddr_o));
    chk("pass/stall", 32'(stall_req_o));
    chk("pass/bus_req", 32'(bus_req_o));

    access("lb",  4'd1, 32'h0000_1001, 32'h0, 32'h00FF_0000, 0,
           32'h0000_1000, 4'b0100, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 2);
    access("lbu", 4'd2, 32'h0000_1001, 32'h0, 32'h00FF_0000, 0,
           32'h0000_1000, 4'b0100, 1'b0, 32'h0, 1'b1, 32'h0000_00FF, 1'b0, 2);
    access("sh",  4'd7, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0, 3,
           32'h0000_2000, 4'b0011, 1'b1, 32'hBEEF_BEEF, 1'b0, 32'h0000_2002, 1'b0, 5);

    // Misaligned word load: flagged at once, no bus, no stall, stays idle
    cycle();
    mem_op_i = 4'd5; mem_wData_i = 32'h0000_3001; mem_wAddr_i = 5'd9; mem_wReg_i = 1'b1;
    push(32'd1); push(32'd0); push(32'd0); push(32'd0);
    #1;
    chk("align/exc_align", 32'(exc_align_o));
    chk("align/bus_req", 32'(bus_req_o));
    chk("align/wb_wReg", 32'(wb_wReg_o));
    chk("align/stall", 32'(stall_req_o));
    cycle();
    mem_op_i = 4'd0;
    push(32'd0); push(32'd0);
    #1;
    chk("align/next_bus_req", 32'(bus_req_o));
    chk("align/next_exc_align", 32'(exc_align_o));

    access("lw_tmo", 4'd5, 32'h0000_4000, 32'h0, 32'h0, -1,
           32'h0000_4000, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5);
    access("lw_late_ack", 4'd5, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 3,
           32'h0000_4000, 4'b1111, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 5);
    access("lh",  4'd3, 32'h0000_5002, 32'h0, 32'h1234_8001, 0,
           32'h0000_5000, 4'b0011, 1'b0, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0, 2);
    access("lhu", 4'd4, 32'h0000_5000, 32'h0, 32'h8001_1234, 1,
           32'h0000_5000, 4'b1100, 1'b0, 32'h0, 1'b1, 32'h0000_8001, 1'b0, 3);
    access("sw",  4'd8, 32'h0000_6000, 32'h1122_3344, 32'h0, 1,
           32'h0000_6000, 4'b1111, 1'b1, 32'h1122_3344, 1'b0, 32'h0000_6000, 1'b0, 3);
    access("sb",  4'd6, 32'h0000_7003, 32'h0000_00AB, 32'h0, 0,
           32'h0000_7000, 4'b0001, 1'b1, 32'hABAB_ABAB, 1'b0, 32'h0000_7003, 1'b0, 2);

    // Reset during the second ACCESS cycle, then a late ack
    cycle();
    mem_op_i = 4'd5; mem_wData_i = 32'h0000_8000; mem_wAddr_i = 5'd4; mem_wReg_i = 1'b1;
    bus_ack_i = 1'b0;
    cycle();
    push(32'd1);
    #1;
    chk("rst_mid/acc1_bus_req", 32'(bus_req_o));
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1357_9BDF;
    mem_op_i = 4'd0; mem_wData_i = 32'h0000_0055;
    push(32'd0); push(32'd0); push(32'd0); push(32'h0000_0055);
    #1;
    chk("rst_mid/bus_req", 32'(bus_req_o));
    chk("rst_mid/stall", 32'(stall_req_o));
    chk("rst_mid/exc_timeout", 32'(exc_timeout_o));
    chk("rst_mid/wb_wData", wb_wData_o);
    cycle();
    push(32'd0); push(32'd0); push(32'h0000_0055);
    #1;
    chk("rst_mid/late_bus_req", 32'(bus_req_o));
    chk("rst_mid/late_exc_timeout", 32'(exc_timeout_o));
    chk("rst_mid/late_wb_wData", wb_wData_o);
    bus_ack_i = 1'b0;

    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
